// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    OWN_CPU,
    OWN_DBG
  } arb_owner_t;

  // Counter value reached on the final cycle of an access lasting wait_cycles cycles.
  function automatic logic [CNT_W-1:0] last_count(input int unsigned wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/mem_arb_wait_cnt.sv
// Wait-cycle counter: counts ACCESS cycles and flags the last one of WAIT_CYCLES.
module mem_arb_wait_cnt
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [CNT_W-1:0] LastCnt = last_count(WAIT_CYCLES);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Not gated by enable; the arbiter qualifies it with its own state.
  assign done = (r_cnt == LastCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a cpu port and a debug/loader port onto one fixed-latency memory.
// Define MEM_ARB_FIXED_PRIO_EN for cpu-wins-ties priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_t        r_state;
  arb_state_t        w_state_d;
  arb_owner_t        r_owner;
  arb_owner_t        w_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_any_req;
  logic              w_start;
  logic              w_access;
  logic              w_done;
  logic              w_capture;

  assign w_any_req = cpu_req | dbg_req;
  assign w_start   = (r_state == IDLE) && w_any_req;
  assign w_access  = (r_state == ACCESS);
  assign w_capture = w_access && w_done && !r_we;

`ifdef MEM_ARB_FIXED_PRIO_EN
  assign w_grant = cpu_req ? OWN_CPU : OWN_DBG;
`else
  arb_owner_t r_last;

  always_comb begin
    w_grant = OWN_CPU;
    if (cpu_req && dbg_req) begin
      w_grant = (r_last == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (dbg_req) begin
      w_grant = OWN_DBG;
    end
  end

  // Reset to dbg so the cpu wins the first tie.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_last <= OWN_DBG;
    end else if (w_start) begin
      r_last <= w_grant;
    end
  end
`endif

  mem_arb_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (w_start),
    .enable(w_access),
    .done  (w_done)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE:    if (w_any_req) w_state_d = ACCESS;
      ACCESS:  if (w_done) w_state_d = RESP;
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_owner <= OWN_CPU;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_owner <= w_grant;
        r_we    <= (w_grant == OWN_DBG) ? dbg_we    : cpu_we;
        r_addr  <= (w_grant == OWN_DBG) ? dbg_addr  : cpu_addr;
        r_wdata <= (w_grant == OWN_DBG) ? dbg_wdata : cpu_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cpu_rdata <= '0;
      r_dbg_rdata <= '0;
    end else if (w_capture) begin
      if (r_owner == OWN_CPU) begin
        r_cpu_rdata <= mem_rdata;
      end else begin
        r_dbg_rdata <= mem_rdata;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_ready = 1'b0;
    dbg_ready = 1'b0;
    unique case (r_state)
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      RESP: begin
        cpu_ready = (r_owner == OWN_CPU);
        dbg_ready = (r_owner == OWN_DBG);
      end
      default: ;
    endcase
  end

  assign cpu_rdata = r_cpu_rdata;
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one instance with WAIT_CYCLES=1 (index 0) and one with 3 (index 1).
module tb_mem_arbiter;

`ifdef MEM_ARB_FIXED_PRIO_EN
  localparam bit FixedPrio = 1'b1;
`else
  localparam bit FixedPrio = 1'b0;
`endif

  typedef struct {
    int          lat;
    int          en_cyc;
    int          we_cyc;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          stable;
    bit          cpu;
    bit          dbg;
    bit          both;
    bit          en_at_rdy;
    bit          timeout;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n   [2];
  logic        c_req   [2];
  logic        c_we    [2];
  logic [31:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic [31:0] c_rdata [2];
  logic        c_rdy   [2];
  logic        d_req   [2];
  logic        d_we    [2];
  logic [31:0] d_addr  [2];
  logic [31:0] d_wdata [2];
  logic [31:0] d_rdata [2];
  logic        d_rdy   [2];
  logic        m_en    [2];
  logic        m_we    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [31:0] m_rdata [2];
  int          en_run  [2];

  // Reference model state
  bit          last_dbg [2];
  logic [31:0] ref_c    [2];
  logic [31:0] ref_d    [2];
  int          n_pass;
  int          n_checks;

  always #5 clk = ~clk;

  mem_arbiter #(.WAIT_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(rst_n[0]),
    .cpu_req(c_req[0]), .cpu_we(c_we[0]), .cpu_addr(c_addr[0]), .cpu_wdata(c_wdata[0]),
    .cpu_rdata(c_rdata[0]), .cpu_ready(c_rdy[0]),
    .dbg_req(d_req[0]), .dbg_we(d_we[0]), .dbg_addr(d_addr[0]), .dbg_wdata(d_wdata[0]),
    .dbg_rdata(d_rdata[0]), .dbg_ready(d_rdy[0]),
    .mem_en(m_en[0]), .mem_we(m_we[0]), .mem_addr(m_addr[0]), .mem_wdata(m_wdata[0]),
    .mem_rdata(m_rdata[0])
  );

  mem_arbiter #(.WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(rst_n[1]),
    .cpu_req(c_req[1]), .cpu_we(c_we[1]), .cpu_addr(c_addr[1]), .cpu_wdata(c_wdata[1]),
    .cpu_rdata(c_rdata[1]), .cpu_ready(c_rdy[1]),
    .dbg_req(d_req[1]), .dbg_we(d_we[1]), .dbg_addr(d_addr[1]), .dbg_wdata(d_wdata[1]),
    .dbg_rdata(d_rdata[1]), .dbg_ready(d_rdy[1]),
    .mem_en(m_en[1]), .mem_we(m_we[1]), .mem_addr(m_addr[1]), .mem_wdata(m_wdata[1]),
    .mem_rdata(m_rdata[1])
  );

  function automatic int wc(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    if (a == 32'h40) return 32'h8C02_0044;
    return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
  endfunction

  // Memory: data valid only from the WAIT_CYCLES-th consecutive enabled cycle on.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      en_run[d]  <= m_en[d] ? en_run[d] + 1 : 0;
      m_rdata[d] <= (m_en[d] && (en_run[d] + 1 >= wc(d))) ? mem_default(m_addr[d])
                                                            : 32'h0BAD_F00D;
    end
  end

  task automatic model_reset(input int d);
    last_dbg[d] = 1'b1;
    ref_c[d]    = '0;
    ref_d[d]    = '0;
  endtask

  task automatic model_complete(input int d, input bit dbg, input bit we, input logic [31:0] a);
    last_dbg[d] = dbg;
    if (!we) begin
      if (dbg) ref_d[d] = mem_default(a);
      else     ref_c[d] = mem_default(a);
    end
  endtask

  task automatic observe(input int d, input int budget, output obs_t o);
    o = '{lat: 0, en_cyc: 0, we_cyc: 0, addr: '0, wdata: '0, stable: 1'b1, cpu: 1'b0,
          dbg: 1'b0, both: 1'b0, en_at_rdy: 1'b0, timeout: 1'b1};
    for (int n = 1; n <= budget; n++) begin
      @(posedge clk); #1;
      if (m_en[d]) begin
        if (o.en_cyc == 0) begin
          o.addr  = m_addr[d];
          o.wdata = m_wdata[d];
        end else if (m_addr[d] !== o.addr || m_wdata[d] !== o.wdata) begin
          o.stable = 1'b0;
        end
        o.en_cyc++;
        if (m_we[d]) o.we_cyc++;
      end
      if (c_rdy[d] && d_rdy[d]) o.both = 1'b1;
      if (c_rdy[d] || d_rdy[d]) begin
        o.cpu       = c_rdy[d];
        o.dbg       = d_rdy[d];
        o.en_at_rdy = m_en[d];
        o.lat       = n;
        o.timeout   = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      c_req[d] = 1'b1; c_we[d] = 1'b1; c_addr[d] = $urandom(); c_wdata[d] = $urandom();
      d_req[d] = 1'b1; d_we[d] = 1'b1; d_addr[d] = $urandom(); d_wdata[d] = $urandom();
    end
    repeat (3) begin @(posedge clk); #1; end
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (m_en[d] !== 1'b0) $display("FAIL reset_mem_en[%0d] got %b want 0", d, m_en[d]); else n_pass++;
      n_checks++; if (m_we[d] !== 1'b0) $display("FAIL reset_mem_we[%0d] got %b want 0", d, m_we[d]); else n_pass++;
      n_checks++; if (m_addr[d] !== 32'h0) $display("FAIL reset_mem_addr[%0d] got %h want 0", d, m_addr[d]); else n_pass++;
      n_checks++; if (m_wdata[d] !== 32'h0) $display("FAIL reset_mem_wdata[%0d] got %h want 0", d, m_wdata[d]); else n_pass++;
      n_checks++; if ({c_rdy[d], d_rdy[d]} !== 2'b00) $display("FAIL reset_ready[%0d] got %b%b want 00", d, c_rdy[d], d_rdy[d]); else n_pass++;
      n_checks++; if (c_rdata[d] !== 32'h0 || d_rdata[d] !== 32'h0) $display("FAIL reset_rdata[%0d] got %h/%h want 0/0", d, c_rdata[d], d_rdata[d]); else n_pass++;
    end
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b1; c_req[d] = 1'b0; d_req[d] = 1'b0;
      model_reset(d);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      n_checks++; if (m_en[d] !== 1'b0) $display("FAIL idle_mem_en[%0d] got %b want 0", d, m_en[d]); else n_pass++;
    end
  endtask

  task automatic test_read();
    obs_t o;
    c_we[0] = 1'b0; c_addr[0] = 32'h40; c_wdata[0] = $urandom(); c_req[0] = 1'b1;
    observe(0, 20, o);
    c_req[0] = 1'b0;
    model_complete(0, 1'b0, 1'b0, 32'h40);
    n_checks++; if (o.timeout) $display("FAIL read_timeout got no ready want ready"); else n_pass++;
    n_checks++; if (o.lat != 2) $display("FAIL read_latency got %0d want 2", o.lat); else n_pass++;
    n_checks++; if (o.en_cyc != 1) $display("FAIL read_mem_en_cycles got %0d want 1", o.en_cyc); else n_pass++;
    n_checks++; if (o.addr !== 32'h40) $display("FAIL read_mem_addr got %h want 00000040", o.addr); else n_pass++;
    n_checks++; if (!o.cpu || o.dbg) $display("FAIL read_owner got cpu=%b dbg=%b want cpu=1 dbg=0", o.cpu, o.dbg); else n_pass++;
    n_checks++; if (o.en_at_rdy) $display("FAIL read_mem_en_in_resp got 1 want 0"); else n_pass++;
    n_checks++; if (c_rdata[0] !== 32'h8C02_0044) $display("FAIL read_cpu_rdata got %h want 8c020044", c_rdata[0]); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (c_rdy[0] !== 1'b0 || d_rdy[0] !== 1'b0) $display("FAIL read_ready_pulse got %b%b want 00", c_rdy[0], d_rdy[0]); else n_pass++;
  endtask

  task automatic test_write();
    obs_t o;
    d_we[0] = 1'b0; d_addr[0] = 32'h104; d_req[0] = 1'b1;
    observe(0, 20, o);
    d_req[0] = 1'b0;
    model_complete(0, 1'b1, 1'b0, 32'h104);
    @(posedge clk); #1;
    d_we[0] = 1'b1; d_addr[0] = 32'h100; d_wdata[0] = 32'hDEAD_BEEF; d_req[0] = 1'b1;
    observe(0, 20, o);
    d_req[0] = 1'b0;
    model_complete(0, 1'b1, 1'b1, 32'h100);
    n_checks++; if (o.timeout || o.lat != 2) $display("FAIL write_latency got %0d (timeout=%b) want 2", o.lat, o.timeout); else n_pass++;
    n_checks++; if (o.we_cyc != 1 || o.en_cyc != 1) $display("FAIL write_mem_we_cycles got we=%0d en=%0d want 1/1", o.we_cyc, o.en_cyc); else n_pass++;
    n_checks++; if (o.addr !== 32'h100) $display("FAIL write_mem_addr got %h want 00000100", o.addr); else n_pass++;
    n_checks++; if (o.wdata !== 32'hDEAD_BEEF) $display("FAIL write_mem_wdata got %h want deadbeef", o.wdata); else n_pass++;
    n_checks++; if (!o.dbg || o.cpu) $display("FAIL write_owner got cpu=%b dbg=%b want cpu=0 dbg=1", o.cpu, o.dbg); else n_pass++;
    n_checks++; if (d_rdata[0] !== ref_d[0]) $display("FAIL write_dbg_rdata_held got %h want %h", d_rdata[0], ref_d[0]); else n_pass++;
    n_checks++; if (c_rdata[0] !== ref_c[0]) $display("FAIL write_cpu_rdata_held got %h want %h", c_rdata[0], ref_c[0]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_tie();
    obs_t o;
    bit   want2_dbg;
    rst_n[0] = 1'b0;
    @(posedge clk); #1;
    rst_n[0] = 1'b1;
    model_reset(0);
    c_we[0] = 1'b0; c_addr[0] = 32'h200; d_we[0] = 1'b0; d_addr[0] = 32'h300;
    c_req[0] = 1'b1; d_req[0] = 1'b1;
    observe(0, 20, o);
    model_complete(0, 1'b0, 1'b0, 32'h200);
    n_checks++; if (o.timeout || !o.cpu || o.dbg) $display("FAIL tie_first_owner got cpu=%b dbg=%b want cpu", o.cpu, o.dbg); else n_pass++;
    n_checks++; if (c_rdata[0] !== ref_c[0]) $display("FAIL tie_first_rdata got %h want %h", c_rdata[0], ref_c[0]); else n_pass++;
    want2_dbg = !FixedPrio;
    observe(0, 20, o);
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    model_complete(0, want2_dbg, 1'b0, want2_dbg ? 32'h300 : 32'h200);
    n_checks++; if (o.timeout || o.dbg !== want2_dbg || o.cpu === want2_dbg) $display("FAIL tie_second_owner got cpu=%b dbg=%b want dbg=%b", o.cpu, o.dbg, want2_dbg); else n_pass++;
    n_checks++; if (o.lat != 3) $display("FAIL tie_spacing got %0d want 3", o.lat); else n_pass++;
    n_checks++; if (d_rdata[0] !== ref_d[0]) $display("FAIL tie_dbg_rdata got %h want %h", d_rdata[0], ref_d[0]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_drop();
    int n_c;
    int n_d;
    bit en_first;
    c_we[0] = 1'b0; c_addr[0] = 32'h44; c_req[0] = 1'b1; d_req[0] = 1'b0;
    @(posedge clk); #1;
    en_first = m_en[0];
    c_req[0] = 1'b0;
    n_c = 0; n_d = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (c_rdy[0]) n_c++;
      if (d_rdy[0]) n_d++;
    end
    model_complete(0, 1'b0, 1'b0, 32'h44);
    n_checks++; if (!en_first) $display("FAIL drop_access_started got mem_en=0 want 1"); else n_pass++;
    n_checks++; if (n_c != 1 || n_d != 0) $display("FAIL drop_ready_pulses got cpu=%0d dbg=%0d want 1/0", n_c, n_d); else n_pass++;
    n_checks++; if (m_en[0] !== 1'b0) $display("FAIL drop_idle_mem_en got %b want 0", m_en[0]); else n_pass++;
    n_checks++; if (c_rdata[0] !== ref_c[0]) $display("FAIL drop_rdata got %h want %h", c_rdata[0], ref_c[0]); else n_pass++;
  endtask

  task automatic test_wait3();
    obs_t o;
    c_we[1] = 1'b0; c_addr[1] = 32'h80; c_req[1] = 1'b1;
    observe(1, 30, o);
    model_complete(1, 1'b0, 1'b0, 32'h80);
    n_checks++; if (o.timeout || o.lat != 4) $display("FAIL w3_latency got %0d want 4", o.lat); else n_pass++;
    n_checks++; if (o.en_cyc != 3 || !o.stable) $display("FAIL w3_mem_en got %0d cycles stable=%b want 3 stable", o.en_cyc, o.stable); else n_pass++;
    n_checks++; if (o.addr !== 32'h80) $display("FAIL w3_mem_addr got %h want 00000080", o.addr); else n_pass++;
    n_checks++; if (c_rdata[1] !== ref_c[1]) $display("FAIL w3_rdata got %h want %h", c_rdata[1], ref_c[1]); else n_pass++;
    c_req[1] = 1'b0; d_we[1] = 1'b0; d_addr[1] = 32'h84; d_req[1] = 1'b1;
    observe(1, 30, o);
    d_req[1] = 1'b0;
    model_complete(1, 1'b1, 1'b0, 32'h84);
    n_checks++; if (o.timeout || o.lat != 5 || !o.dbg) $display("FAIL w3_back_to_back got %0d dbg=%b want 5 dbg=1", o.lat, o.dbg); else n_pass++;
    n_checks++; if (d_rdata[1] !== ref_d[1]) $display("FAIL w3_dbg_rdata got %h want %h", d_rdata[1], ref_d[1]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    obs_t o;
    int   n_r;
    c_we[1] = 1'b0; c_addr[1] = 32'hC0; c_req[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_checks++; if (m_en[1] !== 1'b1) $display("FAIL rmid_in_access got mem_en=%b want 1", m_en[1]); else n_pass++;
    rst_n[1] = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({m_en[1], m_we[1]} !== 2'b00) $display("FAIL rmid_mem_en_we got %b%b want 00", m_en[1], m_we[1]); else n_pass++;
    n_checks++; if (m_addr[1] !== 32'h0 || m_wdata[1] !== 32'h0) $display("FAIL rmid_mem_bus got %h/%h want 0/0", m_addr[1], m_wdata[1]); else n_pass++;
    n_checks++; if ({c_rdy[1], d_rdy[1]} !== 2'b00) $display("FAIL rmid_ready got %b%b want 00", c_rdy[1], d_rdy[1]); else n_pass++;
    n_checks++; if (c_rdata[1] !== 32'h0 || d_rdata[1] !== 32'h0) $display("FAIL rmid_rdata got %h/%h want 0/0", c_rdata[1], d_rdata[1]); else n_pass++;
    rst_n[1] = 1'b1; c_req[1] = 1'b0;
    model_reset(1);
    n_r = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (c_rdy[1] || d_rdy[1]) n_r++;
    end
    n_checks++; if (n_r != 0) $display("FAIL rmid_no_ready got %0d pulses want 0", n_r); else n_pass++;
    c_addr[1] = 32'hC4; c_req[1] = 1'b1;
    observe(1, 30, o);
    c_req[1] = 1'b0;
    model_complete(1, 1'b0, 1'b0, 32'hC4);
    n_checks++; if (o.timeout || o.lat != 4 || !o.cpu) $display("FAIL rmid_recover got lat=%0d cpu=%b want 4/1", o.lat, o.cpu); else n_pass++;
    n_checks++; if (c_rdata[1] !== ref_c[1]) $display("FAIL rmid_recover_rdata got %h want %h", c_rdata[1], ref_c[1]); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_random(input int d, input int n);
    obs_t        o;
    bit          pc;
    bit          pd;
    bit          exp_dbg;
    bit          exp_we;
    logic [31:0] exp_a;
    logic [31:0] exp_wd;
    pc = 1'b0; pd = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (!pc && $urandom_range(0, 1) == 1) begin
        pc = 1'b1; c_we[d] = 1'($urandom_range(0, 1));
        c_addr[d] = $urandom_range(0, 255) << 2; c_wdata[d] = $urandom();
      end
      if (!pd && $urandom_range(0, 1) == 1) begin
        pd = 1'b1; d_we[d] = 1'($urandom_range(0, 1));
        d_addr[d] = $urandom_range(0, 255) << 2; d_wdata[d] = $urandom();
      end
      if (!pc && !pd) begin
        pc = 1'b1; c_we[d] = 1'b0; c_addr[d] = $urandom_range(0, 255) << 2;
      end
      c_req[d] = pc; d_req[d] = pd;
      exp_dbg = (pc && pd) ? (FixedPrio ? 1'b0 : !last_dbg[d]) : pd;
      exp_we  = exp_dbg ? d_we[d]    : c_we[d];
      exp_a   = exp_dbg ? d_addr[d]  : c_addr[d];
      exp_wd  = exp_dbg ? d_wdata[d] : c_wdata[d];
      observe(d, 40, o);
      model_complete(d, exp_dbg, exp_we, exp_a);
      n_checks++; if (o.timeout || o.lat != wc(d) + 1) $display("FAIL rnd%0d_latency[%0d] got %0d want %0d", d, i, o.lat, wc(d) + 1); else n_pass++;
      n_checks++; if (o.dbg !== exp_dbg || o.cpu === exp_dbg || o.both) $display("FAIL rnd%0d_owner[%0d] got cpu=%b dbg=%b want dbg=%b", d, i, o.cpu, o.dbg, exp_dbg); else n_pass++;
      n_checks++; if (o.en_cyc != wc(d) || !o.stable || o.addr !== exp_a) $display("FAIL rnd%0d_access[%0d] got en=%0d addr=%h want en=%0d addr=%h", d, i, o.en_cyc, o.addr, wc(d), exp_a); else n_pass++;
      n_checks++; if (o.we_cyc != (exp_we ? wc(d) : 0)) $display("FAIL rnd%0d_mem_we[%0d] got %0d want %0d", d, i, o.we_cyc, exp_we ? wc(d) : 0); else n_pass++;
      if (exp_we) begin
        n_checks++; if (o.wdata !== exp_wd) $display("FAIL rnd%0d_wdata[%0d] got %h want %h", d, i, o.wdata, exp_wd); else n_pass++;
      end
      n_checks++; if (c_rdata[d] !== ref_c[d] || d_rdata[d] !== ref_d[d]) $display("FAIL rnd%0d_rdata[%0d] got %h/%h want %h/%h", d, i, c_rdata[d], d_rdata[d], ref_c[d], ref_d[d]); else n_pass++;
      if (exp_dbg) begin pd = 1'b0; d_req[d] = 1'b0; end
      else begin pc = 1'b0; c_req[d] = 1'b0; end
      @(posedge clk); #1;
      n_checks++; if (m_en[d] !== 1'b0 || c_rdy[d] !== 1'b0 || d_rdy[d] !== 1'b0) $display("FAIL rnd%0d_idle[%0d] got en=%b rdy=%b%b want 0/00", d, i, m_en[d], c_rdy[d], d_rdy[d]); else n_pass++;
    end
    c_req[d] = 1'b0; d_req[d] = 1'b0;
    repeat (wc(d) + 3) begin @(posedge clk); #1; end
  endtask

  initial begin
    n_pass = 0;
    n_checks = 0;
    en_run = '{0, 0};
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      c_req[d] = 1'b0; c_we[d] = 1'b0; c_addr[d] = '0; c_wdata[d] = '0;
      d_req[d] = 1'b0; d_we[d] = 1'b0; d_addr[d] = '0; d_wdata[d] = '0;
      model_reset(d);
    end
    #1;
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_drop();
    test_wait3();
    test_reset_mid();
    test_random(0, 30);
    test_random(1, 20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
